// File: rtl/beam_pkg.sv
// Shared types and constants for the beamforming datapath stages.
package beam_pkg;

    localparam int unsigned SAMPLE_W         = 16;
    localparam int unsigned SAMPLES_PER_BEAT = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // EMPTY: nothing held, LOW: presenting samples 0..3, HIGH: presenting samples 4..7
    typedef enum logic [1:0] {
        EMPTY,
        LOW,
        HIGH
    } packer_state_t;

endpackage

// File: rtl/beam_frame_counter.sv
// Frame bookkeeping for the S2MM packer: latches the frame length on the first
// accepted pair of a frame and tracks the index of the pair currently held.
module beam_frame_counter #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             accept,       // pair accepted this cycle
    input  logic             frame_end,    // tlast beat handshaken this cycle
    input  logic [LEN_W-1:0] frame_pairs,
    output logic             last_pair,    // held pair is the last of its frame
    output logic             at_boundary   // next accepted pair starts a new frame
);

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;
    logic             in_frame_q;

    assign last_pair   = in_frame_q && (idx_q == (len_q - LEN_W'(1)));
    // While the last pair drains, a refill in the same cycle belongs to the next frame.
    assign at_boundary = !in_frame_q || last_pair;

    // Length latch and pair index; a zero length is treated as one pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            len_q      <= LEN_W'(1);
            idx_q      <= '0;
            in_frame_q <= 1'b0;
        end else if (accept) begin
            if (at_boundary) begin
                len_q      <= (frame_pairs == '0) ? LEN_W'(1) : frame_pairs;
                idx_q      <= '0;
                in_frame_q <= 1'b1;
            end else begin
                idx_q <= idx_q + LEN_W'(1);
            end
        end else if (frame_end) begin
            in_frame_q <= 1'b0;
        end
    end

endmodule

// File: rtl/beam_s2mm_packer.sv
// Joins the real and imaginary beam streams, interleaves them into I/Q words and
// emits two 128-bit beats per input pair, framed with tlast for the S2MM DMA.
// Optional statistics counters are built when BEAM_PACKER_STATS_EN is defined.
module beam_s2mm_packer
    import beam_pkg::*;
#(
    parameter int unsigned SAMPLES = SAMPLES_PER_BEAT,
    parameter int unsigned LEN_W   = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [LEN_W-1:0]              frame_pairs,
    input  logic [SAMPLES*SAMPLE_W-1:0]   s_axis_real_tdata,
    input  logic                          s_axis_real_tvalid,
    output logic                          s_axis_real_tready,
    input  logic                          s_axis_real_tlast,
    input  logic [SAMPLES*SAMPLE_W-1:0]   s_axis_imag_tdata,
    input  logic                          s_axis_imag_tvalid,
    output logic                          s_axis_imag_tready,
    input  logic                          s_axis_imag_tlast,
    output logic [SAMPLES*SAMPLE_W-1:0]   m_axis_s2mm_tdata,
    output logic [SAMPLES*SAMPLE_W/8-1:0] m_axis_s2mm_tkeep,
    output logic                          m_axis_s2mm_tvalid,
    input  logic                          m_axis_s2mm_tready,
    output logic                          m_axis_s2mm_tlast
`ifdef BEAM_PACKER_STATS_EN
    ,
    output logic [31:0]                   frame_count,
    output logic [31:0]                   stall_count
`endif
);

    localparam int unsigned HALF = SAMPLES / 2;

    packer_state_t state_q, state_d;
    logic [SAMPLES*SAMPLE_W-1:0] re_q, im_q;
    logic can_accept, accept, out_hs, frame_end;
    logic last_pair, at_boundary;
    logic unused_tlast;

    // Input tlast carries no meaning here; framing is by count.
    assign unused_tlast = s_axis_real_tlast ^ s_axis_imag_tlast;

    assign m_axis_s2mm_tkeep  = '1;
    assign m_axis_s2mm_tvalid = (state_q != EMPTY);
    assign m_axis_s2mm_tlast  = (state_q == HIGH) && last_pair;
    assign out_hs             = m_axis_s2mm_tvalid && m_axis_s2mm_tready;
    assign frame_end          = out_hs && m_axis_s2mm_tlast;

    // Accept window: empty, or refilling while the HIGH beat leaves this cycle.
    always_comb begin
        can_accept = (state_q == EMPTY) || ((state_q == HIGH) && m_axis_s2mm_tready);
        if (at_boundary && !enable) begin
            can_accept = 1'b0;
        end
        if (reset) begin
            can_accept = 1'b0;
        end
    end

    assign accept             = can_accept && s_axis_real_tvalid && s_axis_imag_tvalid;
    assign s_axis_real_tready = accept;
    assign s_axis_imag_tready = accept;

    // State register and held pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                re_q <= s_axis_real_tdata;
                im_q <= s_axis_imag_tdata;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (accept) state_d = LOW;
            LOW:     if (out_hs) state_d = HIGH;
            HIGH:    if (out_hs) state_d = accept ? LOW : EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output packing: word j = {im[k], re[k]} with k offset by HALF in HIGH.
    always_comb begin
        int unsigned k;
        sample_t     re_s;
        sample_t     im_s;
        k    = 0;
        re_s = '0;
        im_s = '0;
        m_axis_s2mm_tdata = '0;
        if (state_q != EMPTY) begin
            for (int j = 0; j < HALF; j++) begin
                k    = (state_q == HIGH) ? (j + HALF) : j;
                re_s = re_q[SAMPLE_W*k +: SAMPLE_W];
                im_s = im_q[SAMPLE_W*k +: SAMPLE_W];
                m_axis_s2mm_tdata[2*SAMPLE_W*j +: 2*SAMPLE_W] = {im_s, re_s};
            end
        end
    end

    beam_frame_counter #(
        .LEN_W (LEN_W)
    ) u_frame_counter (
        .clock       (clock),
        .reset       (reset),
        .accept      (accept),
        .frame_end   (frame_end),
        .frame_pairs (frame_pairs),
        .last_pair   (last_pair),
        .at_boundary (at_boundary)
    );

`ifdef BEAM_PACKER_STATS_EN
    // Completed frames and output stall cycles, both free-running and wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
            stall_count <= '0;
        end else begin
            if (frame_end) begin
                frame_count <= frame_count + 32'd1;
            end
            if (m_axis_s2mm_tvalid && !m_axis_s2mm_tready) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_beam_s2mm_packer.sv
// Directed bench for beam_s2mm_packer; stats checks are built with BEAM_PACKER_STATS_EN.
module tb_beam_s2mm_packer;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [15:0]  frame_pairs = 16'd1;
    logic [127:0] s_axis_real_tdata = '0;
    logic         s_axis_real_tvalid = 1'b0;
    logic         s_axis_real_tready;
    logic         s_axis_real_tlast = 1'b0;
    logic [127:0] s_axis_imag_tdata = '0;
    logic         s_axis_imag_tvalid = 1'b0;
    logic         s_axis_imag_tready;
    logic         s_axis_imag_tlast = 1'b0;
    logic [127:0] m_axis_s2mm_tdata;
    logic [15:0]  m_axis_s2mm_tkeep;
    logic         m_axis_s2mm_tvalid;
    logic         m_axis_s2mm_tready = 1'b0;
    logic         m_axis_s2mm_tlast;
`ifdef BEAM_PACKER_STATS_EN
    logic [31:0]  frame_count;
    logic [31:0]  stall_count;
`endif

    always #5 clock = ~clock;

    beam_s2mm_packer #(
        .SAMPLES (8),
        .LEN_W   (16)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .enable             (enable),
        .frame_pairs        (frame_pairs),
        .s_axis_real_tdata  (s_axis_real_tdata),
        .s_axis_real_tvalid (s_axis_real_tvalid),
        .s_axis_real_tready (s_axis_real_tready),
        .s_axis_real_tlast  (s_axis_real_tlast),
        .s_axis_imag_tdata  (s_axis_imag_tdata),
        .s_axis_imag_tvalid (s_axis_imag_tvalid),
        .s_axis_imag_tready (s_axis_imag_tready),
        .s_axis_imag_tlast  (s_axis_imag_tlast),
        .m_axis_s2mm_tdata  (m_axis_s2mm_tdata),
        .m_axis_s2mm_tkeep  (m_axis_s2mm_tkeep),
        .m_axis_s2mm_tvalid (m_axis_s2mm_tvalid),
        .m_axis_s2mm_tready (m_axis_s2mm_tready),
        .m_axis_s2mm_tlast  (m_axis_s2mm_tlast)
`ifdef BEAM_PACKER_STATS_EN
        ,
        .frame_count        (frame_count),
        .stall_count        (stall_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 0: ready always high, 1: ready toggles every cycle
    int ready_mode = 0;
    int cyc = 0;
    int tb_stalls = 0;
    logic [127:0] beat_data[$];
    logic         beat_last[$];
    int           beat_cyc[$];
    int           acc_cyc[$];
    logic [127:0] exp_data[$];
    logic         exp_last[$];

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clock);
        #1;
        if (ready_mode == 0) m_axis_s2mm_tready = 1'b1;
        else                 m_axis_s2mm_tready = ~m_axis_s2mm_tready;
    end

    // Output monitor: collects beats, accept times and checks stall stability.
    initial begin
        logic         stall_prev;
        logic [127:0] prev_data;
        logic         prev_last;
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", 128'(m_axis_s2mm_tvalid), 128'(1));
                    check("stall_data", m_axis_s2mm_tdata, prev_data);
                    check("stall_last", 128'(m_axis_s2mm_tlast), 128'(prev_last));
                end
                check("tready_join", 128'(s_axis_real_tready), 128'(s_axis_imag_tready));
                if (m_axis_s2mm_tvalid && m_axis_s2mm_tready) begin
                    beat_data.push_back(m_axis_s2mm_tdata);
                    beat_last.push_back(m_axis_s2mm_tlast);
                    beat_cyc.push_back(cyc);
                end
                if (s_axis_real_tready) acc_cyc.push_back(cyc);
                if (m_axis_s2mm_tvalid && !m_axis_s2mm_tready) tb_stalls++;
                stall_prev = m_axis_s2mm_tvalid && !m_axis_s2mm_tready;
                prev_data  = m_axis_s2mm_tdata;
                prev_last  = m_axis_s2mm_tlast;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_all();
        beat_data.delete();
        beat_last.delete();
        beat_cyc.delete();
        acc_cyc.delete();
        exp_data.delete();
        exp_last.delete();
    endtask

    task automatic send_pair(input logic [127:0] re, input logic [127:0] im);
        int n;
        n = 0;
        s_axis_real_tdata  = re;
        s_axis_imag_tdata  = im;
        s_axis_real_tvalid = 1'b1;
        s_axis_imag_tvalid = 1'b1;
        @(negedge clock);
        while (!s_axis_real_tready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) check("accept_timeout", 128'(n), 128'(0));
        tick();
        s_axis_real_tvalid = 1'b0;
        s_axis_imag_tvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (beat_data.size() < n && t < 500) begin
            @(negedge clock);
            t++;
        end
        if (t >= 500) check("beat_timeout", 128'(beat_data.size()), 128'(n));
        repeat (3) tick();
    endtask

    function automatic logic [127:0] mk(input int p, input bit imag);
        logic [127:0] v;
        for (int k = 0; k < 8; k++) v[16*k +: 16] = 16'(p * 256 + k + (imag ? 16'h8000 : 0));
        return v;
    endfunction

    // Reference interleave: word j = {im[j+b], re[j+b]}, b = 4 for the upper half.
    function automatic logic [127:0] pack(input logic [127:0] re, input logic [127:0] im,
                                          input bit hi);
        logic [127:0] r;
        int b;
        b = hi ? 4 : 0;
        for (int j = 0; j < 4; j++) r[32*j +: 32] = {im[16*(j+b) +: 16], re[16*(j+b) +: 16]};
        return r;
    endfunction

    task automatic expect_pair(input int p, input bit last);
        exp_data.push_back(pack(mk(p, 1'b0), mk(p, 1'b1), 1'b0));
        exp_last.push_back(1'b0);
        exp_data.push_back(pack(mk(p, 1'b0), mk(p, 1'b1), 1'b1));
        exp_last.push_back(last);
    endtask

    task automatic compare(input string tag);
        check({tag, "_nbeats"}, 128'(beat_data.size()), 128'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < beat_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), beat_data[i], exp_data[i]);
            check($sformatf("%s_last%0d", tag, i), 128'(beat_last[i]), 128'(exp_last[i]));
        end
    endtask

    initial begin
        logic [127:0] ramp_re, ramp_im;
        logic [127:0] c_ab;
        int gap;
`ifdef BEAM_PACKER_STATS_EN
        logic [31:0] fc0, sc0;
`endif
        for (int k = 0; k < 8; k++) begin
            ramp_re[16*k +: 16] = 16'(k);
            ramp_im[16*k +: 16] = 16'(16 + k);
        end
        c_ab = 128'h00B000A0_00B000A0_00B000A0_00B000A0;

        // Reset with valid inputs presented
        reset = 1'b1;
        enable = 1'b1;
        s_axis_real_tdata = ramp_re;
        s_axis_imag_tdata = ramp_im;
        s_axis_real_tvalid = 1'b1;
        s_axis_imag_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("rst_tvalid", 128'(m_axis_s2mm_tvalid), 128'(0));
            check("rst_tlast", 128'(m_axis_s2mm_tlast), 128'(0));
            check("rst_tdata", m_axis_s2mm_tdata, 128'(0));
            check("rst_real_tready", 128'(s_axis_real_tready), 128'(0));
            check("rst_imag_tready", 128'(s_axis_imag_tready), 128'(0));
            check("rst_tkeep", 128'(m_axis_s2mm_tkeep), 128'(16'hFFFF));
`ifdef BEAM_PACKER_STATS_EN
            check("rst_frame_count", 128'(frame_count), 128'(0));
            check("rst_stall_count", 128'(stall_count), 128'(0));
`endif
        end
        tick();
        s_axis_real_tvalid = 1'b0;
        s_axis_imag_tvalid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_tvalid", 128'(m_axis_s2mm_tvalid), 128'(0));
        check("post_rst_beats", 128'(beat_data.size()), 128'(0));
        tick();

        // Single frame of two pairs, continuous ready
        clear_all();
        frame_pairs = 16'd2;
        send_pair({8{16'h00A0}}, {8{16'h00B0}});
        send_pair({8{16'h00A0}}, {8{16'h00B0}});
        wait_beats(4);
        check("sf_nbeats", 128'(beat_data.size()), 128'(4));
        if (beat_data.size() == 4 && acc_cyc.size() == 2) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("sf_data%0d", i), beat_data[i], c_ab);
                check($sformatf("sf_last%0d", i), 128'(beat_last[i]), 128'(i == 3));
            end
            gap = acc_cyc[1] - acc_cyc[0];
            check("sf_accept_gap", 128'(gap), 128'(2));
            gap = beat_cyc[0] - acc_cyc[0];
            check("sf_latency", 128'(gap), 128'(1));
            gap = beat_cyc[3] - beat_cyc[0];
            check("sf_no_bubble", 128'(gap), 128'(3));
        end
        check("sf_accepts", 128'(acc_cyc.size()), 128'(2));

        // Join skew: real valid three cycles ahead of imag
        clear_all();
        frame_pairs = 16'd1;
        s_axis_real_tdata = ramp_re;
        s_axis_real_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("skew_real_tready", 128'(s_axis_real_tready), 128'(0));
            check("skew_imag_tready", 128'(s_axis_imag_tready), 128'(0));
        end
        tick();
        send_pair(ramp_re, ramp_im);
        wait_beats(2);
        check("skew_accepts", 128'(acc_cyc.size()), 128'(1));
        exp_data.push_back(128'h0013_0003_0012_0002_0011_0001_0010_0000);
        exp_last.push_back(1'b0);
        exp_data.push_back(128'h0017_0007_0016_0006_0015_0005_0014_0004);
        exp_last.push_back(1'b1);
        compare("skew");

        // Backpressure: ready toggling, 32 pairs in frames of 4
        clear_all();
        frame_pairs = 16'd4;
`ifdef BEAM_PACKER_STATS_EN
        fc0 = frame_count;
        sc0 = stall_count;
`endif
        tb_stalls = 0;
        ready_mode = 1;
        for (int p = 0; p < 32; p++) begin
            send_pair(mk(p, 1'b0), mk(p, 1'b1));
            expect_pair(p, (p % 4) == 3);
        end
        wait_beats(64);
        ready_mode = 0;
        repeat (3) tick();
        compare("bp");
        check("bp_accepts", 128'(acc_cyc.size()), 128'(32));
`ifdef BEAM_PACKER_STATS_EN
        check("bp_stall_count", 128'(stall_count - sc0), 128'(tb_stalls));
        check("bp_frame_count", 128'(frame_count - fc0), 128'(8));
`endif

        // Enable dropped mid-frame: frame of 3 completes, then no accept
        clear_all();
        frame_pairs = 16'd3;
        send_pair(mk(40, 1'b0), mk(40, 1'b1));
        enable = 1'b0;
        send_pair(mk(41, 1'b0), mk(41, 1'b1));
        send_pair(mk(42, 1'b0), mk(42, 1'b1));
        s_axis_real_tvalid = 1'b1;
        s_axis_imag_tvalid = 1'b1;
        repeat (8) begin
            @(negedge clock);
            check("en_low_tready", 128'(s_axis_real_tready), 128'(0));
        end
        tick();
        s_axis_real_tvalid = 1'b0;
        s_axis_imag_tvalid = 1'b0;
        enable = 1'b1;
        wait_beats(6);
        expect_pair(40, 1'b0);
        expect_pair(41, 1'b0);
        expect_pair(42, 1'b1);
        compare("en_low");
        check("en_low_accepts", 128'(acc_cyc.size()), 128'(3));

        // Zero length behaves as one pair per frame
        clear_all();
        frame_pairs = 16'd0;
        for (int p = 50; p < 53; p++) begin
            send_pair(mk(p, 1'b0), mk(p, 1'b1));
            expect_pair(p, 1'b1);
        end
        wait_beats(6);
        compare("len0");

        // Length change mid-frame applies only from the next frame
        clear_all();
        frame_pairs = 16'd2;
        send_pair(mk(60, 1'b0), mk(60, 1'b1));
        frame_pairs = 16'd1;
        send_pair(mk(61, 1'b0), mk(61, 1'b1));
        send_pair(mk(62, 1'b0), mk(62, 1'b1));
        wait_beats(6);
        expect_pair(60, 1'b0);
        expect_pair(61, 1'b1);
        expect_pair(62, 1'b1);
        compare("lenchg");

        // Reset after 3 of 5 pairs; next frame needs 5 full pairs
        clear_all();
        frame_pairs = 16'd5;
        for (int p = 70; p < 73; p++) send_pair(mk(p, 1'b0), mk(p, 1'b1));
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("rstmid_tvalid", 128'(m_axis_s2mm_tvalid), 128'(0));
        tick();
        clear_all();
        for (int p = 80; p < 85; p++) begin
            send_pair(mk(p, 1'b0), mk(p, 1'b1));
            expect_pair(p, p == 84);
        end
        wait_beats(10);
        compare("rstmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beam_s2mm_packer.md
# beam_s2mm_packer

Downstream stage of the four-channel beamforming adder. It joins one beam's separate real and imaginary AXI-Stream outputs, each carrying 8 signed 16-bit samples per beat. It interleaves them into complex I/Q words and splits each input pair into two 128-bit output beats. It also cuts the output into fixed-length frames with `tlast` for the S2MM DMA.

## Interface
- `SAMPLES` = 8: int16 samples per input beat; output carries SAMPLES/2 complex words per beat.
- `LEN_W` = 16: width of `frame_pairs`.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: allows new frames to start.
- `frame_pairs` in LEN_W: input pairs per frame; sampled at frame start; 0 is treated as 1.
- `s_axis_real_tdata` in 128: real samples; sample k occupies [16k+15:16k].
- `s_axis_real_tvalid` in 1: real beat valid.
- `s_axis_real_tready` out 1: real beat accepted.
- `s_axis_real_tlast` in 1: ignored.
- `s_axis_imag_tdata` / `_tvalid` / `_tready` / `_tlast`: same widths and rules as the real port.
- `m_axis_s2mm_tdata` out 128: interleaved I/Q.
- `m_axis_s2mm_tkeep` out 16: constant 16'hFFFF.
- `m_axis_s2mm_tvalid` out 1: output beat valid.
- `m_axis_s2mm_tready` in 1: DMA ready.
- `m_axis_s2mm_tlast` out 1: last beat of the frame.

## Operation
- **Join:**
  - Both `s_*_tready` are asserted together, equal to `can_accept & real_tvalid & imag_tvalid`.
  - A pair is consumed only when both streams are valid; a lone valid stream is never consumed.
- **`can_accept`:**
  - True in EMPTY.
  - True in HIGH when `m_tready` is high (same-cycle refill).
  - Forced false when at a frame boundary and `enable` is low.
- **Holding register:** 256 bits (real + imag) loaded on accept.
- **FSM states:**
  - EMPTY: no beat pending.
  - LOW: presenting samples 0..3.
  - HIGH: presenting samples 4..7.
- **FSM transitions:**
  - EMPTY→LOW on accept.
  - LOW→HIGH on output handshake.
  - HIGH→LOW on output handshake with a simultaneous accept.
  - HIGH→EMPTY on output handshake without an accept.
- **Output beat packing:** for word j = 0..3, bits [32j+15:32j] = re[k] and [32j+31:32j+16] = im[k], where k = j in LOW and k = j+4 in HIGH. This is a pure bit copy with no arithmetic or saturation.
- **Frame counter:**
  - Counts accepted pairs.
  - `frame_pairs` is latched into a length register when the first pair of a frame is accepted.
  - `m_tlast` is high on the HIGH beat of the pair whose index equals latched length−1.
  - The counter returns to 0 (frame boundary) on that beat's handshake.
- **`enable` low:**
  - Mid-frame: the current frame completes normally.
  - At a boundary: no new pair is accepted.
- **`frame_pairs` changes mid-frame:** ignored until the next frame start.
- **Reset mid-operation:** the held pair, partial frame and counters are discarded; the next accepted pair starts a new frame at index 0.

## Timing
- **Reset values:** `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, both `s_tready`=0, state EMPTY, counters 0. `tkeep` is always 16'hFFFF.
- **Latency:** a pair accepted at edge N presents its LOW beat as valid after edge N (registered), i.e. 1 cycle.
- **Throughput:** 2 output beats per input pair. Under continuous `m_tready`, inputs are accepted every 2nd cycle with no bubble on output.
- **Output stability:** `m_tvalid`, `m_tdata` and `m_tlast` stay stable while `m_tvalid & !m_tready`. They never depend combinationally on `m_tready`.
- **Input ready:** `s_tready` depends combinationally on `m_tready` only in the HIGH state.

## Configuration
- Macro `BEAM_PACKER_STATS_EN`.
- **When defined:**
  - Adds output `frame_count` (32 bits): increments on every `tlast` handshake.
  - Adds output `stall_count` (32 bits): increments each cycle with `m_tvalid & !m_tready`.
  - Both counters wrap at 2^32 and reset to 0.
- **When undefined:** the ports and logic are absent; all other behaviour is identical.

## Structure
- **Shared package `beam_pkg`:**
  - `SAMPLE_W`=16 and `SAMPLES_PER_BEAT`=8.
  - `sample_t` (signed 16-bit).
  - `packer_state_t` enum {EMPTY, LOW, HIGH}.
- **One sub-module, `beam_frame_counter`:**
  - Inputs: pair-accept strobe, `frame_pairs`, reset.
  - Outputs: `last_pair` flag and `at_boundary` flag.
  - Contains the latched length and the index counter.

## Test plan
- **Reset:** hold `reset` 3 cycles with valid inputs → all outputs 0, `s_tready`=0, no beat emitted.
- **Single frame:**
  - Setup: `frame_pairs`=2, real=8×16'h00A0, imag=8×16'h00B0, `m_tready`=1.
  - Expected: 4 beats of 128'h00B000A0 repeated ×4; `tlast` only on beat 4; `s_tready` pulses every 2 cycles.
- **Join skew:**
  - Setup: real valid 3 cycles before imag.
  - Expected: no accept until both are valid; then the pair is accepted once, with correct sample order for ramp data re[k]=k, im[k]=16+k.
- **Backpressure:**
  - Setup: `m_tready` toggles 1010…
  - Expected: data and `tlast` held stable during stalls; no loss or duplication over 32 pairs; `stall_count` equals the number of stall cycles (with STATS_EN).
- **Enable and length boundaries:**
  - Enable low mid-frame: the frame finishes with `tlast`, then `s_tready` stays 0.
  - `frame_pairs`=0: every pair's HIGH beat carries `tlast`.
  - `frame_pairs` changed mid-frame: the current frame keeps the old length.
- **Reset mid-frame:**
  - Setup: reset after 3 of 5 pairs.
  - Expected: the held beat is dropped; the next frame's `tlast` comes after 5 full pairs.
